// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath widths, reset PC, bubble encoding
// and the per-cycle action classification used by the PC/IF-ID update logic.
package if_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0, x0, 0 -- what downstream inserts when ifid_valid is low
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        CYC_RESET,
        CYC_REDIRECT,
        CYC_STALL,
        CYC_SEQ
    } cycle_e;

endpackage

// File: rtl/if_stage_pc_adder4.sv
// Combinational PC + 4, modulo 2^XLEN; the carry-out is deliberately dropped.
module pc_adder4
    import if_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] sum
);

    assign sum = pc + INSTR_BYTES;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the perf_fetch / perf_stall performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [XLEN-1:0] ifid_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetch,
    output logic [XLEN-1:0] perf_stall
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    cycle_e          cycle;

    pc_adder4 u_pc_adder4 (
        .pc  (pc),
        .sum (pc_plus4)
    );

    assign imem_addr = pc;

    // A redirect outranks a stall: the instruction being held is on the wrong path anyway.
    always_comb begin
        cycle = CYC_SEQ;
        if (rst)
            cycle = CYC_RESET;
        else if (br_taken)
            cycle = CYC_REDIRECT;
        else if (stall)
            cycle = CYC_STALL;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values of pc and pc_plus4, regardless of statement order.
    always_ff @(posedge clk) begin
        case (cycle)
            CYC_RESET: begin
                pc         <= RESET_PC;
                ifid_valid <= 1'b0;
                ifid_pc    <= '0;
                ifid_pc4   <= '0;
                ifid_instr <= '0;
            end
            CYC_REDIRECT: begin
                pc         <= {br_target[XLEN-1:2], 2'b00};
                ifid_valid <= 1'b0;
            end
            CYC_STALL: begin
                pc         <= pc;
            end
            default: begin
                pc         <= pc_plus4;
                ifid_valid <= 1'b1;
                ifid_pc    <= pc;
                ifid_pc4   <= pc_plus4;
                ifid_instr <= imem_rdata;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (cycle == CYC_RESET) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (cycle == CYC_SEQ)
                perf_fetch <= perf_fetch + 1'b1;
            if (cycle == CYC_STALL)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors, a behavioural fetch model checked every
// cycle, and literal expectations at key points of the sequence.
module tb_if_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;
    localparam logic [31:0] IMEM_KEY    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory: every word is its own address scrambled by a fixed key.
    assign imem_rdata = imem_addr ^ IMEM_KEY;

    if_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what a fetch stage must hold after each edge.
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fetch, m_stall;
    logic        m_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1'b1;
            m_pc    = TB_RESET_PC;
            m_valid = 1'b0;
            m_ipc   = 0;
            m_ipc4  = 0;
            m_instr = 0;
            m_fetch = 0;
            m_stall = 0;
        end else if (m_known) begin
            if (br_taken) begin
                m_pc    = br_target & ~32'd3;
                m_valid = 1'b0;
            end else if (stall) begin
                m_stall = m_stall + 1;
            end else begin
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 4;
                m_instr = m_pc ^ IMEM_KEY;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
                m_fetch = m_fetch + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("imem_addr", imem_addr, m_pc);
            check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("ifid_pc", ifid_pc, m_ipc);
                check("ifid_pc4", ifid_pc4, m_ipc4);
                check("ifid_instr", ifid_instr, m_instr);
            end
`ifdef IF_PERF_CNT_EN
            check("perf_fetch", perf_fetch, m_fetch);
            check("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst       = r;
        stall     = s;
        br_taken  = b;
        br_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 32'h0000_7000);
        check("rst_addr", imem_addr, 32'h0000_1000);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_pc4", ifid_pc4, 32'd0);
        check("rst_ifid_instr", ifid_instr, 32'd0);

        // Three free cycles after reset.
        cyc(0, 0, 0, 0);
        check("seq0_valid", {31'd0, ifid_valid}, 32'd1);
        check("seq0_pc", ifid_pc, 32'h0000_1000);
        check("seq0_instr", ifid_instr, 32'hA5A5_B5A5);
        cyc(0, 0, 0, 0);
        check("seq1_pc", ifid_pc, 32'h0000_1004);
        cyc(0, 0, 0, 0);
        check("seq2_pc", ifid_pc, 32'h0000_1008);
        check("seq2_pc4", ifid_pc4, 32'h0000_100C);
        check("seq2_addr", imem_addr, 32'h0000_100C);

        // Two-cycle stall: everything frozen.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0);
            check("stall_addr", imem_addr, 32'h0000_100C);
            check("stall_ifid_pc", ifid_pc, 32'h0000_1008);
            check("stall_instr", ifid_instr, 32'hA5A5_B5AD);
        end
        cyc(0, 0, 0, 0);
        check("resume_pc", ifid_pc, 32'h0000_100C);

        // Redirect with an unaligned target while stalled.
        cyc(0, 1, 1, 32'h0000_2003);
        check("redir_addr", imem_addr, 32'h0000_2000);
        check("redir_valid", {31'd0, ifid_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        check("redir_ifid_pc", ifid_pc, 32'h0000_2000);
        check("redir_ifid_valid", {31'd0, ifid_valid}, 32'd1);

        // Back-to-back redirects; a stall while invalid keeps valid low.
        cyc(0, 0, 1, 32'h0000_3000);
        cyc(0, 0, 1, 32'h0000_4001);
        check("b2b_addr", imem_addr, 32'h0000_4000);
        check("b2b_valid", {31'd0, ifid_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        check("b2b_stall_valid", {31'd0, ifid_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        check("b2b_ifid_pc", ifid_pc, 32'h0000_4000);

        // Wrap past the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_ifid_pc4", ifid_pc4, 32'h0000_0000);
        check("wrap_addr0", imem_addr, 32'h0000_0000);
        cyc(0, 0, 0, 0);
        check("wrap_addr1", imem_addr, 32'h0000_0004);

        // Reset in the middle of a stall with a redirect pending.
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 32'h0000_5000);
        check("midrst_addr", imem_addr, 32'h0000_1000);
        check("midrst_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("midrst_perf_fetch", perf_fetch, 32'd0);
        check("midrst_perf_stall", perf_stall, 32'd0);
`endif

        // Counter workload: 10 free, 3 stall, 1 redirect.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_6000);
        check("cnt_addr", imem_addr, 32'h0000_6000);
        check("cnt_hold_pc", ifid_pc, 32'h0000_1024);
`ifdef IF_PERF_CNT_EN
        check("cnt_perf_fetch", perf_fetch, 32'd10);
        check("cnt_perf_stall", perf_stall, 32'd3);
`endif
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
